ex_alu: RTL

Execute-stage ALU that consumes the 4-bit `alu_ctrl` code produced by ALU control, together with the ID/EX operands, and returns a registered 32-bit result plus a branch-condition flag to the EX/MEM stage. Input and output use valid/ready handshakes. Shifts are either single-cycle (barrel) or iterative (one bit per cycle), selected at build time. A synchronous flush from hazard control drops any in-flight operation.

---
 rtl/ex_alu.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_alu.sv
// Execute-stage ALU: registered 32-bit result, branch flag and illegal flag behind valid/ready handshakes.
// Build macro EX_ALU_FAST_SHIFT_EN selects a barrel shifter; otherwise shifts iterate one bit per cycle.
module ex_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_cond,
    output logic            illegal,
    output logic            dbg_state
);
    // Handshake: a transfer happens at a rising clk edge where valid && ready are both high;
    // the output side holds result/br_cond/illegal stable while out_valid && !out_ready.
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_NOTEQ = 4'd10;
    localparam logic [3:0] OP_SGE   = 4'd11;
    localparam logic [3:0] OP_SGEU  = 4'd12;
    localparam logic [3:0] OP_JUMP  = 4'd13;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            accept;
    logic [4:0]      shamt;
    logic [XLEN-1:0] calc_res;
    logic            calc_br;
    logic            calc_ill;
    logic            load;
    logic [XLEN-1:0] load_res;
    logic            load_br;
    logic            load_ill;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            br_q, br_d;
    logic            ill_q, ill_d;

    assign shamt  = op_b[4:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        calc_res = '0;
        calc_br  = 1'b0;
        calc_ill = 1'b0;
        case (alu_ctrl)
            OP_ADD:   calc_res = op_a + op_b;
            OP_SUB:   begin calc_res = op_a - op_b; calc_br = (op_a == op_b); end
            OP_SLT:   begin calc_br = ($signed(op_a) < $signed(op_b)); calc_res[0] = calc_br; end
            OP_SLTU:  begin calc_br = (op_a < op_b); calc_res[0] = calc_br; end
            OP_SGE:   begin calc_br = ($signed(op_a) >= $signed(op_b)); calc_res[0] = calc_br; end
            OP_SGEU:  begin calc_br = (op_a >= op_b); calc_res[0] = calc_br; end
            OP_NOTEQ: begin calc_br = (op_a != op_b); calc_res[0] = calc_br; end
            OP_XOR:   calc_res = op_a ^ op_b;
            OP_OR:    calc_res = op_a | op_b;
            OP_AND:   calc_res = op_a & op_b;
`ifdef EX_ALU_FAST_SHIFT_EN
            OP_SLL:   calc_res = op_a << shamt;
            OP_SRL:   calc_res = op_a >> shamt;
            OP_SRA:   calc_res = $signed(op_a) >>> shamt;
`else
            // Only reaches the output register for a zero shift amount.
            OP_SLL, OP_SRL, OP_SRA: calc_res = op_a;
`endif
            OP_JUMP:  begin calc_res = pc + XLEN'(4); calc_br = 1'b1; end
            default:  calc_ill = 1'b1;
        endcase
    end

`ifdef EX_ALU_FAST_SHIFT_EN
    assign load     = accept;
    assign load_res = calc_res;
    assign load_br  = calc_br;
    assign load_ill = calc_ill;
`else
    logic            is_shift;
    logic [XLEN-1:0] sh_q, sh_d, sh_in, sh_one;
    logic [3:0]      sh_op_q, sh_op_d, sh_op;
    logic [4:0]      cnt_q, cnt_d;

    assign is_shift = alu_ctrl inside {OP_SLL, OP_SRL, OP_SRA};

    // One shared single-bit shifter: fed from the operand on accept, from sh_q while shifting.
    always_comb begin
        sh_in = (state_q == S_SHIFT) ? sh_q : op_a;
        sh_op = (state_q == S_SHIFT) ? sh_op_q : alu_ctrl;
        case (sh_op)
            OP_SLL:  sh_one = {sh_in[XLEN-2:0], 1'b0};
            OP_SRL:  sh_one = {1'b0, sh_in[XLEN-1:1]};
            default: sh_one = {sh_in[XLEN-1], sh_in[XLEN-1:1]};
        endcase
    end

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        sh_op_d  = sh_op_q;
        load     = 1'b0;
        load_res = calc_res;
        load_br  = calc_br;
        load_ill = calc_ill;
        if (state_q == S_SHIFT) begin
            sh_d  = sh_one;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                load     = 1'b1;
                load_res = sh_one;
                load_br  = 1'b0;
                load_ill = 1'b0;
            end
        end else if (accept) begin
            if (is_shift && shamt != 5'd0) begin
                // The accept cycle already performs the first bit, so latency equals shamt.
                sh_d    = sh_one;
                cnt_d   = shamt - 5'd1;
                sh_op_d = alu_ctrl;
                if (shamt == 5'd1) begin
                    load     = 1'b1;
                    load_res = sh_one;
                end
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            sh_op_q <= OP_SLL;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            sh_op_q <= sh_op_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) state_d = S_IDLE;
`ifndef EX_ALU_FAST_SHIFT_EN
        else if (state_q == S_IDLE && accept && is_shift && shamt > 5'd1) state_d = S_SHIFT;
        else if (state_q == S_SHIFT && cnt_q == 5'd1) state_d = S_IDLE;
`endif
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        dbg_state = (state_q == S_SHIFT);
    end

    // Flush wins over load and hold; the data fields only change on a load.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        br_d        = br_q;
        ill_d       = ill_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            result_d    = load_res;
            br_d        = load_br;
            ill_d       = load_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            br_q        <= br_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign br_cond   = br_q;
    assign illegal   = ill_q;
endmodule
